// File: rtl/mem_pkg.sv
// Encodings shared by the decoder, EX/MEM register and the MEM stage:
// access size and MEM-stage access states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } memSize_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } memState_t;

    // The reserved size behaves as a word, so it needs word alignment too.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);

    logic signed [7:0]  laneByte;
    logic signed [15:0] laneHalf;

    always_comb begin
        case (offset)
            2'd0:    laneByte = rdata[7:0];
            2'd1:    laneByte = rdata[15:8];
            2'd2:    laneByte = rdata[23:16];
            default: laneByte = rdata[31:24];
        endcase
        laneHalf = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = {{24{isSigned & laneByte[7]}}, laneByte};
            SZ_HALF: result = {{16{isSigned & laneHalf[15]}}, laneHalf};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one handshaked data-memory access per load/store,
// stalls the pipeline until it completes or times out, and aligns load data.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ValidM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignedM,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MemFaultM,
    output logic              BusErrM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    memState_t        state, stateNext;
    logic             acc, misaligned, issue, timeoutHit;
    logic [CNT_W-1:0] timeoutCnt;
    logic [31:0]      storeData;
    logic [3:0]       storeBe;
    logic [1:0]       offsetR, sizeR;
    logic             signedR, loadR;
    logic [31:0]      alignedData;

    always_comb begin
        acc        = ValidM & (MemtoRegM | MemWriteM);
        misaligned = isMisaligned(MemSizeM, ALUOutM[1:0]);
        MemFaultM  = acc & misaligned;
        issue      = acc & ~misaligned;
        timeoutHit = (timeoutCnt == CNT_LAST);

        case (MemSizeM)
            SZ_BYTE: begin
                storeData = {4{WriteDataM[7:0]}};
                storeBe   = 4'b0001 << ALUOutM[1:0];
            end
            SZ_HALF: begin
                storeData = {2{WriteDataM[15:0]}};
                storeBe   = ALUOutM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = WriteDataM;
                storeBe   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= stateNext;
    end

    // DONE always returns to IDLE so the instruction still sitting in M is not re-issued.
    always_comb begin
        stateNext = state;
        StallM    = 1'b0;
        case (state)
            ST_IDLE: begin
                StallM = issue;
                if (issue) stateNext = ST_REQ;
            end
            ST_REQ: begin
                StallM = 1'b1;
                if (dmem_ack || timeoutHit) stateNext = ST_DONE;
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    mem_load_align uLoadAlign (
        .rdata    (dmem_rdata),
        .offset   (offsetR),
        .size     (sizeR),
        .isSigned (signedR),
        .result   (alignedData)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            ReadDataM  <= '0;
            BusErrM    <= 1'b0;
            timeoutCnt <= '0;
            offsetR    <= '0;
            sizeR      <= '0;
            signedR    <= 1'b0;
            loadR      <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                ST_IDLE: if (issue) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= MemWriteM;
                    dmem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
                    dmem_wdata <= MemWriteM ? storeData : 32'h0;
                    dmem_be    <= MemWriteM ? storeBe : 4'b1111;
                    offsetR    <= ALUOutM[1:0];
                    sizeR      <= MemSizeM;
                    signedR    <= MemSignedM;
                    loadR      <= ~MemWriteM;
                    timeoutCnt <= '0;
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (loadR) ReadDataM <= alignedData;
                    end else if (timeoutHit) begin
                        dmem_req  <= 1'b0;
                        ReadDataM <= '0;
                        BusErrM   <= 1'b1;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                ST_DONE: timeoutCnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized loads/stores
// checked against a byte-lane reference model and a responding memory.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ValidM, MemtoRegM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallM, MemFaultM, BusErrM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    localparam int TO = 16;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallM(StallM), .MemFaultM(MemFaultM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata)
    );

    always #5 CLK = ~CLK;

    int errs = 0;
    int checks = 0;

    // expected ReadDataM register content
    logic [31:0] modelRead;

    // observations from the last access
    int          obsStall, obsReq, obsErrPulses;
    bit          obsStable, obsTimeout, obsDoneReq, obsAfterReq, obsAfterStall, obsAfterErr;
    logic [31:0] obsAddr, obsWdata, obsRead, obsAfterRead;
    logic [3:0]  obsBe;
    logic        obsWe;

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] sizeMask(input int n);
        return (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sg);
        int n = nBytes(sz);
        logic [31:0] v, m;
        m = sizeMask(n);
        v = (rd >> (8 * off)) & m;
        if (sg && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] wd, input logic [1:0] sz);
        int n = nBytes(sz);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4 / n; i++) r = r | ((wd & sizeMask(n)) << (8 * n * i));
        return r;
    endfunction

    function automatic logic [3:0] refBe(input logic [1:0] sz, input logic [1:0] off);
        int n = nBytes(sz);
        logic [3:0] m = (n == 1) ? 4'h1 : (n == 2) ? 4'h3 : 4'hF;
        return m << off;
    endfunction

    task automatic goIdle();
        ValidM = 0; MemtoRegM = 0; MemWriteM = 0; dmem_ack = 0;
    endtask

    // Presents one access in M and plays the memory side; ackAt is the REQ cycle
    // (1-based) that acks, 0 meaning never.
    task automatic runAccess(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int ackAt);
        bit done = 0;
        obsStall = 0; obsReq = 0; obsErrPulses = 0; obsStable = 1; obsTimeout = 0; obsDoneReq = 0;
        @(negedge CLK);
        ValidM = 1; MemtoRegM = !st; MemWriteM = st; MemSizeM = sz; MemSignedM = sg;
        ALUOutM = addr; WriteDataM = wd; dmem_ack = 0; dmem_rdata = $urandom;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (BusErrM) obsErrPulses++;
            if (StallM) begin
                obsStall++;
                if (dmem_req) begin
                    obsReq++;
                    if (obsReq == 1) begin
                        obsAddr = dmem_addr; obsWdata = dmem_wdata; obsBe = dmem_be; obsWe = dmem_we;
                    end else if ({dmem_addr, dmem_wdata, dmem_be, dmem_we} !== {obsAddr, obsWdata, obsBe, obsWe}) begin
                        obsStable = 0;
                    end
                    dmem_ack   = (obsReq == ackAt);
                    dmem_rdata = (obsReq == ackAt) ? rd : $urandom;
                end else begin
                    dmem_ack = 0;
                end
                @(negedge CLK);
            end else begin
                done = 1; obsRead = ReadDataM; obsDoneReq = dmem_req;
            end
        end
        if (!done) obsTimeout = 1;
        @(negedge CLK);
        goIdle();
        #1;
        obsAfterReq = dmem_req; obsAfterStall = StallM; obsAfterErr = BusErrM; obsAfterRead = ReadDataM;
        if (obsAfterErr) obsErrPulses++;
    endtask

    task automatic test_reset();
        RST_N = 0; goIdle(); MemSizeM = 0; MemSignedM = 0; ALUOutM = 0; WriteDataM = 0; dmem_rdata = 0;
        #3;
        checks++; if ({dmem_req, dmem_we, dmem_be, BusErrM, StallM} !== 8'h0) begin
            errs++; $display("FAIL reset_ctrl: got %b required 0", {dmem_req, dmem_we, dmem_be, BusErrM, StallM});
        end
        checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
            errs++; $display("FAIL reset_bus: got addr=%h wdata=%h required 0", dmem_addr, dmem_wdata);
        end
        checks++; if (ReadDataM !== 32'h0) begin
            errs++; $display("FAIL reset_rdata: got %h required 0", ReadDataM);
        end
        @(negedge CLK); RST_N = 1; modelRead = 0;
    endtask

    task automatic test_word_load();
        runAccess(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        modelRead = 32'hDEADBEEF;
        checks++; if (obsStall !== 2) begin errs++; $display("FAIL wload_stall: got %0d required 2", obsStall); end
        checks++; if (obsRead !== modelRead) begin errs++; $display("FAIL wload_data: got %h required %h", obsRead, modelRead); end
        checks++; if (obsBe !== 4'hF || obsWe !== 1'b0 || obsAddr !== 32'h100) begin
            errs++; $display("FAIL wload_bus: got be=%b we=%b addr=%h required 1111 0 00000100", obsBe, obsWe, obsAddr);
        end
        checks++; if (obsAfterReq || obsAfterStall || obsDoneReq) begin
            errs++; $display("FAIL wload_reissue: got req=%b stall=%b required 0 0", obsAfterReq, obsAfterStall);
        end
    endtask

    task automatic test_byte_load();
        runAccess(0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234, 1);
        checks++; if (obsRead !== 32'hFFFFFF80) begin errs++; $display("FAIL sbyte_load: got %h required ffffff80", obsRead); end
        runAccess(0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234, 2);
        modelRead = 32'h00000080;
        checks++; if (obsRead !== modelRead) begin errs++; $display("FAIL ubyte_load: got %h required 00000080", obsRead); end
        checks++; if (obsAddr !== 32'h100) begin errs++; $display("FAIL ubyte_addr: got %h required 00000100", obsAddr); end
    endtask

    task automatic test_half_store();
        runAccess(1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h12345678, 3);
        checks++; if (obsWdata !== 32'hABCDABCD || obsBe !== 4'b1100 || obsAddr !== 32'h20 || obsWe !== 1'b1) begin
            errs++; $display("FAIL hstore_bus: got wdata=%h be=%b addr=%h we=%b required abcdabcd 1100 00000020 1",
                             obsWdata, obsBe, obsAddr, obsWe);
        end
        checks++; if (obsReq !== 3 || !obsStable) begin errs++; $display("FAIL hstore_req: got cycles=%0d stable=%0d required 3 1", obsReq, obsStable); end
        checks++; if (obsStall !== 4) begin errs++; $display("FAIL hstore_stall: got %0d required 4", obsStall); end
        checks++; if (obsRead !== modelRead) begin errs++; $display("FAIL hstore_rdata: got %h required %h", obsRead, modelRead); end
    endtask

    task automatic test_misaligned();
        bit sawReq = 0, sawStall = 0, sawNoFault = 0;
        logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ads [3] = '{32'h101, 32'h203, 32'h302};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ValidM = 1; MemtoRegM = 1; MemWriteM = 0; MemSizeM = szs[i]; ALUOutM = ads[i];
            for (int c = 0; c < 3; c++) begin
                #1;
                if (dmem_req) sawReq = 1;
                if (StallM) sawStall = 1;
                if (!MemFaultM) sawNoFault = 1;
                @(negedge CLK);
            end
        end
        goIdle(); #1;
        checks++; if (sawNoFault) begin errs++; $display("FAIL fault_flag: got MemFaultM=0 at some cycle required 1"); end
        checks++; if (sawReq || sawStall) begin errs++; $display("FAIL fault_noreq: got req=%0d stall=%0d required 0 0", sawReq, sawStall); end
        checks++; if (MemFaultM !== 1'b0) begin errs++; $display("FAIL fault_bubble: got %b required 0", MemFaultM); end
    endtask

    task automatic test_bubble();
        bit sawStall = 0;
        @(negedge CLK);
        ValidM = 1; MemtoRegM = 0; MemWriteM = 0; ALUOutM = 32'h101;
        for (int c = 0; c < 3; c++) begin
            #1; if (StallM || dmem_req || MemFaultM) sawStall = 1;
            dmem_ack = 1; dmem_rdata = $urandom;
            @(negedge CLK);
        end
        goIdle(); #1;
        checks++; if (sawStall) begin errs++; $display("FAIL nonmem_stall: got activity required none"); end
        checks++; if (ReadDataM !== modelRead) begin errs++; $display("FAIL nonmem_hold: got %h required %h", ReadDataM, modelRead); end
    endtask

    task automatic test_timeout();
        runAccess(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 0);
        modelRead = 32'h0;
        checks++; if (obsReq !== TO) begin errs++; $display("FAIL to_reqcycles: got %0d required %0d", obsReq, TO); end
        checks++; if (obsErrPulses !== 1 || obsAfterErr) begin errs++; $display("FAIL to_buserr: got pulses=%0d required 1", obsErrPulses); end
        checks++; if (obsRead !== 32'h0) begin errs++; $display("FAIL to_rdata: got %h required 0", obsRead); end
        checks++; if (obsStall !== TO + 1 || obsAfterStall || obsAfterReq) begin
            errs++; $display("FAIL to_stall: got %0d required %0d", obsStall, TO + 1);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge CLK);
        ValidM = 1; MemtoRegM = 1; MemWriteM = 0; MemSizeM = 2'b10; ALUOutM = 32'h40;
        @(negedge CLK); #1;
        checks++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL rst_pre_req: got %b required 1", dmem_req); end
        RST_N = 0; goIdle(); #1;
        modelRead = 32'h0;
        checks++; if ({dmem_req, dmem_we, dmem_be, BusErrM, StallM} !== 8'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
            errs++; $display("FAIL rst_mid_out: got req=%b be=%b addr=%h required all 0", dmem_req, dmem_be, dmem_addr);
        end
        @(negedge CLK);
        RST_N = 1; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (StallM !== 1'b0) begin errs++; $display("FAIL rst_late_stall: got %b required 0", StallM); end
        @(negedge CLK); dmem_ack = 0; #1;
        checks++; if (dmem_req !== 1'b0 || ReadDataM !== modelRead || BusErrM !== 1'b0) begin
            errs++; $display("FAIL rst_late_ack: got req=%b rdata=%h required 0 %h", dmem_req, ReadDataM, modelRead);
        end
        runAccess(0, 2'b01, 1, 32'h46, 32'h0, 32'h8001_7FFF, 2);
        modelRead = 32'hFFFF8001;
        checks++; if (obsRead !== modelRead || obsStall !== 3) begin
            errs++; $display("FAIL rst_follow: got rdata=%h stall=%0d required %h 3", obsRead, obsStall, modelRead);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic        st = $urandom_range(0, 1);
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic        sg = $urandom_range(0, 1);
            logic [31:0] addr = $urandom & ~(32'(nBytes(sz)) - 32'h1);
            logic [31:0] wd = $urandom, rd = $urandom;
            int          ackAt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            int          expReq = (ackAt == 0) ? TO : ackAt;
            runAccess(st, sz, sg, addr, wd, rd, ackAt);
            if (ackAt == 0) modelRead = 32'h0;
            else if (!st) modelRead = refLoad(rd, addr[1:0], sz, sg);
            checks++; if (obsRead !== modelRead || obsAfterRead !== modelRead) begin
                errs++; $display("FAIL rnd_rdata[%0d]: got %h required %h", i, obsRead, modelRead);
            end
            checks++; if (obsStall !== expReq + 1 || obsReq !== expReq || !obsStable || obsTimeout) begin
                errs++; $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d stable=%0d required %0d %0d 1",
                                 i, obsStall, obsReq, obsStable, expReq + 1, expReq);
            end
            checks++; if (obsAddr !== {addr[31:2], 2'b00} || obsWe !== st ||
                          obsBe !== (st ? refBe(sz, addr[1:0]) : 4'hF)) begin
                errs++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b be=%b", i, obsAddr, obsWe, obsBe);
            end
            if (st) begin
                checks++; if (obsWdata !== refWdata(wd, sz)) begin
                    errs++; $display("FAIL rnd_wdata[%0d]: got %h required %h", i, obsWdata, refWdata(wd, sz));
                end
            end
            checks++; if (obsErrPulses !== ((ackAt == 0) ? 1 : 0) || obsAfterReq || obsAfterStall) begin
                errs++; $display("FAIL rnd_err[%0d]: got pulses=%0d required %0d", i, obsErrPulses, (ackAt == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_bubble();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores to a handshaked data-memory port.
  - Stores: byte-lane alignment and byte enables.
  - Loads: lane extraction plus sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Produces ReadDataM, which the MEM/WB register captures.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles without ack before the access is abandoned with a bus error.
- ADDR_W, 32: data-memory address width (word-aligned bus; low 2 bits select lanes).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ValidM  in  1  M-stage holds a real (non-bubble) instruction.
- MemtoRegM  in  1  instruction is a load.
- MemWriteM  in  1  instruction is a store.
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- MemSignedM  in  1  load sign-extends when 1, zero-extends when 0.
- ALUOutM  in  32  effective address.
- WriteDataM  in  32  store data (right-justified).
- ReadDataM  out  32  aligned/extended load result to MEM/WB.
- StallM  out  1  holds PC, IF/ID, ID/EX and EX/MEM; MEM/WB must insert a bubble.
- MemFaultM  out  1  misaligned access (combinational).
- BusErrM  out  1  one-cycle pulse: access timed out.
- dmem_req  out  1  request valid (registered).
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word address, {ALUOutM[ADDR_W-1:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  memory completes request this cycle.
- dmem_rdata  in  32  read data, valid with dmem_ack.

Behaviour:
- Reset (async, RST_N low), all take effect immediately: state=IDLE, dmem_req/we=0, dmem_addr/wdata=0, dmem_be=0, ReadDataM=0, BusErrM=0, timeout counter=0. An access in flight is abandoned; a late ack after reset is ignored.
- Access valid: acc = ValidM & (MemtoRegM | MemWriteM).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. MemFaultM = acc & misaligned.
  - A misaligned access issues no request and raises no stall; the hazard/control unit kills it.
- State IDLE:
  - StallM = acc & ~misaligned.
  - On that condition: register addr, we, be, wdata, and size/signed/offset for the load; set dmem_req=1; go to REQ.
  - Otherwise stay; StallM=0.
- State REQ:
  - StallM=1. dmem_req and all bus outputs held stable until ack.
  - dmem_ack=1: capture ReadDataM (loads only; stores leave ReadDataM unchanged), dmem_req=0, go to DONE.
  - No ack: counter++. When counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req=0, ReadDataM=0, BusErrM=1 for the next cycle, go to DONE.
- State DONE:
  - StallM=0 for exactly one cycle, so the pipeline advances and MEM/WB captures ReadDataM. Counter cleared.
  - Next state IDLE unconditionally. This prevents re-issuing the still-present instruction.
- Minimum access latency: 3 cycles in M (IDLE, REQ with same-cycle ack, DONE).
- Ack on the first REQ cycle is legal. dmem_ack in IDLE/DONE is ignored.
- Non-memory instruction or bubble: no stall; ReadDataM holds its last value.
- Store lanes:
  - byte: wdata = {4{WriteDataM[7:0]}}, be = 0001 << addr[1:0].
  - half: wdata = {2{WriteDataM[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata = WriteDataM, be = 1111.
- Loads: dmem_we=0 and be=1111. Lane selected by the registered addr[1:0], then extended to 32 bits per size/signed.

Decomposition:
- Shared package mem_pkg: MemSizeM encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (ST_IDLE, ST_REQ, ST_DONE). The EX/MEM register and decoder use the same encodings.
- One sub-module, mem_load_align: combinational (rdata, offset, size, signed) -> 32-bit result. Unit-testable in isolation.

Test Plan:
- Word load, addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> StallM high for 2 cycles, ReadDataM=0xDEADBEEF in DONE, dmem_be=1111, we=0.
- Signed byte load, addr 0x103, rdata 0x80FF_1234 -> ReadDataM=0xFFFFFF80. Unsigned same -> 0x00000080.
- Half store, addr 0x22, WriteDataM 0x0000ABCD, ack after 3 cycles:
  - dmem_wdata=0xABCDABCD, be=1100, addr=0x20.
  - req held stable 3 cycles; stall for 4 cycles total.
- Word load at addr 0x101 -> MemFaultM=1, dmem_req never asserted, StallM=0.
- No ack, TIMEOUT_CYCLES=16 -> req drops after 16 REQ cycles, BusErrM pulses once, ReadDataM=0, state back to IDLE.
- RST_N low during REQ, then ack asserted next cycle:
  - dmem_req=0 immediately on reset; all outputs at reset values.
  - After release, the late ack is ignored, no stall, and a following load proceeds normally.
